// File: rtl/latency_data_memory.sv
// Purpose: word-addressed data memory responder with a fixed, programmable access latency (CSN/WEN/BE strobes).
// Latency: acceptance at edge k, array access at edge k+LATENCY, MEM_VALID high the following cycle.
// Backpressure: MEM_RDY low while an access is in flight; one request per LATENCY+1 cycles back-to-back.
// Build option DMEM_POSTED_WRITE_EN: writes complete one edge after acceptance; reads keep full LATENCY.
module latency_data_memory #(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 4
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              MEM_CSN,
    input  logic              MEM_WEN,
    input  logic [3:0]        MEM_BE,
    input  logic [ADDR_W-1:0] MEM_ADDR,
    input  logic [31:0]       MEM_DI,
    output logic [31:0]       MEM_DOUT,
    output logic              MEM_RDY,
    output logic              MEM_VALID
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [7:0]          cnt;
    logic [7:0]          start_cnt;
    logic [ADDR_W-1:0]   req_addr;
    logic                req_wen;
    logic [3:0]          req_be;
    logic [31:0]         req_di;
    logic                accept;
    logic                access;

    // Storage is deliberately not reset: contents survive RSTn.
    logic [31:0]         mem [0:(1<<ADDR_W)-1];

    assign MEM_RDY   = RSTn & ((state == IDLE) | (state == RESP));
    assign MEM_VALID = (state == RESP);
    assign accept    = MEM_RDY & ~MEM_CSN;
    assign access    = (state == BUSY) && (cnt == 8'd0);

`ifdef DMEM_POSTED_WRITE_EN
    // Writes are retired at the very next edge; reads still wait the full latency.
    assign start_cnt = MEM_WEN ? 8'(LATENCY - 1) : 8'd0;
`else
    assign start_cnt = 8'(LATENCY - 1);
`endif

    // State register.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: accept in IDLE/RESP, count down in BUSY, single RESP cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = BUSY;
            BUSY:    if (cnt == 8'd0) state_nxt = RESP;
            RESP:    state_nxt = accept ? BUSY : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch and latency counter; the requester may drop its inputs after acceptance.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cnt      <= 8'd0;
            req_addr <= '0;
            req_wen  <= 1'b1;
            req_be   <= 4'd0;
            req_di   <= 32'd0;
        end else if (accept) begin
            cnt      <= start_cnt;
            req_addr <= MEM_ADDR;
            req_wen  <= MEM_WEN;
            req_be   <= MEM_BE;
            req_di   <= MEM_DI;
        end else if ((state == BUSY) && (cnt != 8'd0)) begin
            cnt <= cnt - 8'd1;
        end
    end

    // Read data register: only a completing read updates it, so it holds across writes.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            MEM_DOUT <= 32'd0;
        end else if (access && req_wen) begin
            MEM_DOUT <= mem[req_addr];
        end
    end

    // Byte-masked array write; a reset mid-access forces IDLE so the write is dropped.
    always_ff @(posedge CLK) begin
        if (access && !req_wen) begin
            for (int i = 0; i < 4; i++) begin
                if (req_be[i]) begin
                    mem[req_addr][8*i +: 8] <= req_di[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_latency_data_memory.sv
// Purpose: self-checking bench for latency_data_memory using a scoreboard of expected completions.
// Latency: each expectation carries the cycle its MEM_VALID must appear in, plus read data.
// Backpressure: the driver waits (bounded) for MEM_RDY before presenting a request.
module tb_latency_data_memory;

`ifdef DMEM_POSTED_WRITE_EN
    localparam int L    = 8;
    localparam int WLAT = 1;
`else
    localparam int L    = 4;
    localparam int WLAT = 4;
`endif

    logic        CLK;
    logic        RSTn;
    logic        MEM_CSN;
    logic        MEM_WEN;
    logic [3:0]  MEM_BE;
    logic [11:0] MEM_ADDR;
    logic [31:0] MEM_DI;
    logic [31:0] MEM_DOUT;
    logic        MEM_RDY;
    logic        MEM_VALID;

    latency_data_memory #(.ADDR_W(12), .LATENCY(L)) dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .MEM_CSN   (MEM_CSN),
        .MEM_WEN   (MEM_WEN),
        .MEM_BE    (MEM_BE),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_DI    (MEM_DI),
        .MEM_DOUT  (MEM_DOUT),
        .MEM_RDY   (MEM_RDY),
        .MEM_VALID (MEM_VALID)
    );

    typedef struct {
        bit          rd;
        logic [31:0] data;
        int          cyc;
    } sb_t;

    sb_t sb[$];
    sb_t mon_e;
    int  n_tests = 0;
    int  n_fail  = 0;
    int  cyc     = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Cycle index: value k during the cycle that follows rising edge k.
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every completion pulse must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (MEM_VALID === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_valid: got pulse at cyc %0d expected none", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("valid_cycle", cyc, mon_e.cyc);
                if (mon_e.rd) check("read_data", MEM_DOUT, mon_e.data);
            end
        end
    end

    // Present one request when MEM_RDY allows; returns the acceptance cycle.
    task automatic do_req(input logic wen, input logic [11:0] addr, input logic [3:0] be,
                          input logic [31:0] di, input logic [31:0] exp, input bit push,
                          output int acc);
        int w;
        sb_t e;
        w   = 0;
        acc = -1;
        @(negedge CLK);
        while (MEM_RDY !== 1'b1 && w < 100) begin
            @(negedge CLK);
            w++;
        end
        if (MEM_RDY !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL req_timeout: got MEM_RDY=%b expected 1 within 100 cycles", MEM_RDY);
            return;
        end
        MEM_CSN  = 1'b0;
        MEM_WEN  = wen;
        MEM_ADDR = addr;
        MEM_BE   = be;
        MEM_DI   = di;
        @(posedge CLK);
        #1;
        acc      = cyc;
        MEM_CSN  = 1'b1;
        MEM_WEN  = ~wen;
        MEM_ADDR = ~addr;
        MEM_BE   = ~be;
        MEM_DI   = ~di;
        if (push) begin
            e.rd   = wen;
            e.data = exp;
            e.cyc  = acc + (wen ? L : WLAT);
            sb.push_back(e);
        end
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 300) begin
            @(posedge CLK);
            w++;
        end
        #1;
        check("drain_empty", sb.size(), 0);
    endtask

    int a0;
    int a1;

    initial begin
        RSTn     = 1'b0;
        MEM_CSN  = 1'b1;
        MEM_WEN  = 1'b1;
        MEM_BE   = 4'h0;
        MEM_ADDR = 12'h000;
        MEM_DI   = 32'h0;

        // Reset state.
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_rdy", MEM_RDY, 0);
        check("rst_valid", MEM_VALID, 0);
        check("rst_dout", MEM_DOUT, 32'h0);
        RSTn = 1'b1;
        @(posedge CLK);
        #1;
        check("post_rst_rdy", MEM_RDY, 1);

        // Write then read; MEM_RDY low for the whole in-flight window.
        do_req(1'b0, 12'h010, 4'hF, 32'hDEADBEEF, 32'h0, 1'b1, a0);
        for (int i = 0; i < WLAT; i++) begin
            check("busy_rdy", MEM_RDY, 0);
            @(posedge CLK);
            #1;
        end
        check("resp_rdy", MEM_RDY, 1);
        do_req(1'b1, 12'h010, 4'h0, 32'h0, 32'hDEADBEEF, 1'b1, a0);
        wait_drain();

        // Byte enables, including an all-zero mask.
        do_req(1'b0, 12'h030, 4'hF, 32'h11223344, 32'h0, 1'b1, a0);
        do_req(1'b0, 12'h030, 4'b0101, 32'hAABBCCDD, 32'h0, 1'b1, a0);
        do_req(1'b1, 12'h030, 4'h0, 32'h0, 32'h11BB33DD, 1'b1, a0);
        do_req(1'b0, 12'h030, 4'b0000, 32'hCAFEBABE, 32'h0, 1'b1, a0);
        do_req(1'b1, 12'h030, 4'hF, 32'h0, 32'h11BB33DD, 1'b1, a0);

        // Back-to-back: accepted in the previous RESP cycle.
        do_req(1'b1, 12'h010, 4'h0, 32'h0, 32'hDEADBEEF, 1'b1, a1);
        check("b2b_spacing", a1 - a0, L + 1);

        // CSN held low while BUSY must not start another access.
        do_req(1'b1, 12'h030, 4'h0, 32'h0, 32'h11BB33DD, 1'b1, a0);
        MEM_CSN = 1'b0;
        for (int i = 0; i < L - 1; i++) begin
            @(posedge CLK);
            #1;
            check("csn_busy_rdy", MEM_RDY, 0);
        end
        MEM_CSN = 1'b1;
        wait_drain();

`ifndef DMEM_POSTED_WRITE_EN
        // Reset mid-access drops the pending write and its completion.
        do_req(1'b0, 12'h020, 4'hF, 32'h00000000, 32'h0, 1'b1, a0);
        wait_drain();
        do_req(1'b0, 12'h020, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0, a0);
        repeat (2) @(posedge CLK);
        #1;
        RSTn = 1'b0;
        #1;
        check("midrst_rdy", MEM_RDY, 0);
        check("midrst_valid", MEM_VALID, 0);
        check("midrst_dout", MEM_DOUT, 32'h0);
        @(posedge CLK);
        #1;
        RSTn = 1'b1;
        do_req(1'b1, 12'h020, 4'h0, 32'h0, 32'h00000000, 1'b1, a0);
        wait_drain();
`endif

        repeat (L + 3) @(posedge CLK);
        #1;
        check("final_sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/latency_data_memory.md
Name: latency_data_memory

Overview:
- Memory-side responder for the data-cache refill/write interface; models word-addressed data memory with a fixed, programmable access latency.
- Accepts one request at a time over a CSN/WEN/BE strobe interface gated by a RDY/VALID handshake; returns read data, or a write-done pulse, after LATENCY cycles.
- Sits below the D-cache in simulation and FPGA builds; replaces the zero-latency synchronous data memory.

Parameters:
- ADDR_W, 12, word-address width; storage depth = 2**ADDR_W 32-bit words.
- LATENCY, 4, cycles from request acceptance to access edge; legal range 1..255.

Ports:
- CLK  input  1  clock, all state on rising edge.
- RSTn  input  1  reset, asynchronous, active-low.
- MEM_CSN  input  1  request strobe, active-low, sampled only when MEM_RDY=1.
- MEM_WEN  input  1  0=write, 1=read; sampled with MEM_CSN.
- MEM_BE  input  4  byte enables for writes; bit i selects byte [8i+7:8i].
- MEM_ADDR  input  ADDR_W  word address.
- MEM_DI  input  32  write data from requester.
- MEM_DOUT  output  32  registered read data.
- MEM_RDY  output  1  responder can accept a request this cycle.
- MEM_VALID  output  1  one-cycle completion pulse (read data valid or write done).

Behaviour:
- Reset (RSTn=0, asynchronous): state=IDLE, counter=0, MEM_VALID=0, MEM_DOUT=0, latched request cleared; MEM_RDY=0 while RSTn=0. Array contents are retained, not cleared.
- States: IDLE, BUSY, RESP.
- MEM_RDY = RSTn & (state==IDLE | state==RESP); combinational from state.
- Accept: at a rising edge with MEM_RDY=1 and MEM_CSN=0:
  - latch ADDR, WEN, BE, DI;
  - counter <= LATENCY-1;
  - state <= BUSY.
- BUSY:
  - if counter!=0: counter decrements.
  - if counter==0: perform the access at this edge; state <= RESP.
    - Read: MEM_DOUT <= array[addr]; full word returned regardless of BE.
    - Write: array bytes with BE[i]=1 updated; MEM_DMEM_DOUT unchanged.
- Timing: request accepted at edge k -> access at edge k+LATENCY -> MEM_VALID=1 for exactly the cycle following edge k+LATENCY.
- RESP: MEM_VALID=1.
  - If MEM_CSN=0 in this cycle, a new request is accepted (state BUSY); otherwise state <= IDLE.
  - Back-to-back throughput is one request per LATENCY+1 cycles.
- MEM_VALID is 0 in IDLE and BUSY.
- MEM_DOUT holds the last read value until the next read completes; writes never change it.
- Inputs are don't-care while MEM_RDY=0; the requester is not required to hold them after acceptance.
- BE=4'b0000 write: no array change; still completes with a MEM_VALID pulse.
- Address is used modulo 2**ADDR_W; no out-of-range detection.
- Reset asserted mid-BUSY: pending access is dropped, no array write occurs, no MEM_VALID pulse.
- Read of a word never written returns X in simulation; the bench must not check it.

Optional Feature:
- Macro: DMEM_POSTED_WRITE_EN.
- Defined: writes are posted.
  - The array is written at the edge following acceptance.
  - MEM_VALID pulses in the next cycle regardless of LATENCY.
  - Reads keep full LATENCY.
  - A read accepted in that RESP cycle observes the written data.
- Undefined: writes take LATENCY cycles exactly as reads.

Test Plan:
- Reset then idle: RSTn low 3 cycles -> MEM_RDY=0, MEM_VALID=0, MEM_DOUT=0. Release -> MEM_RDY=1 on the next cycle.
- Write then read, LATENCY=4:
  - write ADDR=12'h010, DI=32'hDEADBEEF, BE=4'hF at edge k -> MEM_RDY=0 for cycles k..k+3; MEM_VALID pulse after edge k+4.
  - read ADDR=12'h010 -> MEM_DOUT=32'hDEADBEEF with MEM_VALID 4 cycles after acceptance.
- Byte enables: preload 32'h11223344, write DI=32'hAABBCCDD with BE=4'b0101 -> read returns 32'h11BB33DD. BE=0 write -> word unchanged, MEM_VALID still pulses.
- Back-to-back: issue a read in the RESP cycle of the previous access -> accepted without an IDLE cycle; two VALID pulses 5 cycles apart (LATENCY=4). CSN=0 while BUSY is ignored: no extra VALID.
- Reset mid-access: write 32'h0 to addr 12'h020 and complete; accept a write of 32'hCAFEF00D to 12'h020, assert RSTn=0 two cycles later -> no MEM_VALID; after release, read 12'h020 returns 32'h0.
- DMEM_POSTED_WRITE_EN defined, LATENCY=8: write -> MEM_VALID one cycle after acceptance; immediate read of the same address -> written data after 8 cycles.
